circular_right_rotator_pipelined: RTL and testbench



---
 rtl/circular_right_rotator_pipelined.sv | 102 ++++++++++
 tb/tb_circular_right_rotator_pipelined.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/circular_right_rotator_pipelined.sv
// Pipelined circular right rotator: one barrel stage per clock, valid/ready on both ends.
// Optional build macro CIRC_ROTATOR_BIDIR_EN adds an up_left input for per-word left rotation.
module circular_right_rotator_pipelined #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
`ifdef CIRC_ROTATOR_BIDIR_EN
    input  logic         up_left,
`endif
    input  logic [N-1:0] up_data,
    input  logic [W-1:0] up_amount,
    output logic         down_valid,
    input  logic         down_ready,
    output logic [N-1:0] down_data
);

    // Stage registers; the full amount travels with the word and stage k consumes bit k.
    logic         valid_q [W];
    logic [N-1:0] data_q  [W];
    logic [W-1:0] amt_q   [W];

    // Stage inputs (previous stage or upstream port) and rotated results.
    logic         s_valid [W];
    logic [N-1:0] s_data  [W];
    logic [W-1:0] s_amt   [W];
    logic [N-1:0] s_rot   [W];
    logic         ready   [W+1];

`ifdef CIRC_ROTATOR_BIDIR_EN
    logic         left_q  [W];
    logic         s_left  [W];
`endif

    assign ready[W]   = down_ready;
    assign up_ready   = ready[0];
    assign down_valid = valid_q[W-1];
    assign down_data  = data_q[W-1];

    for (genvar k = 0; k < W; k++) begin : g_stage
        localparam int SH = 1 << k;

        if (k == 0) begin : g_head
            assign s_valid[k] = up_valid;
            assign s_data[k]  = up_data;
            assign s_amt[k]   = up_amount;
`ifdef CIRC_ROTATOR_BIDIR_EN
            assign s_left[k]  = up_left;
`endif
        end else begin : g_body
            assign s_valid[k] = valid_q[k-1];
            assign s_data[k]  = data_q[k-1];
            assign s_amt[k]   = amt_q[k-1];
`ifdef CIRC_ROTATOR_BIDIR_EN
            assign s_left[k]  = left_q[k-1];
`endif
        end

        // A stage may load when it is empty or its contents move on this edge.
        assign ready[k] = !valid_q[k] || ready[k+1];

        logic [N-1:0] rot_right;
        assign rot_right = {s_data[k][SH-1:0], s_data[k][N-1:SH]};

`ifdef CIRC_ROTATOR_BIDIR_EN
        logic [N-1:0] rot_left;
        assign rot_left = {s_data[k][N-SH-1:0], s_data[k][N-1:N-SH]};
        assign s_rot[k] = !s_amt[k][k] ? s_data[k] :
                          (s_left[k] ? rot_left : rot_right);
`else
        assign s_rot[k] = s_amt[k][k] ? rot_right : s_data[k];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < W; k++) valid_q[k] <= 1'b0;
        end else begin
            for (int k = 0; k < W; k++) begin
                if (ready[k]) valid_q[k] <= s_valid[k];
            end
        end
    end

    // NOTE: payload registers are deliberately left out of reset; valid_q alone says
    // whether their contents mean anything, so a reset value would never be observed.
    always_ff @(posedge clk) begin
        for (int k = 0; k < W; k++) begin
            if (ready[k] && s_valid[k]) begin
                data_q[k] <= s_rot[k];
                amt_q[k]  <= s_amt[k];
`ifdef CIRC_ROTATOR_BIDIR_EN
                left_q[k] <= s_left[k];
`endif
            end
        end
    end

endmodule

// File: tb/tb_circular_right_rotator_pipelined.sv
// Scoreboard bench for circular_right_rotator_pipelined: expected words are queued at
// acceptance and popped by an independent monitor whenever a result transfers downstream.
module tb_circular_right_rotator_pipelined;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         up_valid = 1'b0;
    logic         up_ready;
    logic         up_left = 1'b0;
    logic [N-1:0] up_data = '0;
    logic [W-1:0] up_amount = '0;
    logic         down_valid;
    logic         down_ready;
    logic [N-1:0] down_data;

    logic         rand_mode = 1'b0;
    logic         rand_bit  = 1'b0;
    logic         dr_level  = 1'b1;

    int           checks = 0;
    int           errors = 0;
    int           stalls = 0;
    logic [N-1:0] exp_q [$];

    assign down_ready = rand_mode ? rand_bit : dr_level;

    circular_right_rotator_pipelined #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
`ifdef CIRC_ROTATOR_BIDIR_EN
        .up_left    (up_left),
`endif
        .up_data    (up_data),
        .up_amount  (up_amount),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: rotate right by a, or left by a (= right by N-a), via a doubled word.
    function automatic logic [N-1:0] model(input logic [N-1:0] d, input int a, input logic left);
        logic [2*N-1:0] dd;
        int             r;
        dd = {d, d};
        r  = left ? (N - a) % N : a;
        return N'(dd >> r);
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [N-1:0] d, input int a, input logic l, input logic [N-1:0] e);
        int waited = 0;
        up_valid  = 1'b1;
        up_data   = d;
        up_amount = W'(a);
        up_left   = l;
        forever begin
            #1;
            if (up_ready) break;
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                check("send_timeout", waited, 0);
                break;
            end
        end
        stalls += waited;
        if (waited <= 200) exp_q.push_back(e);
        @(negedge clk);
        up_valid  = 1'b0;
        up_data   = N'($urandom);
        up_amount = W'($urandom);
        up_left   = 1'($urandom);
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        #3;
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: compare every downstream transfer against the head of the scoreboard.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && down_valid && down_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_output", int'(down_data), -1);
            end else begin
                check("result", int'(down_data), int'(exp_q.pop_front()));
            end
        end
    end

    always begin
        @(negedge clk);
        rand_bit = 1'($urandom);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] sweep_exp [N];
        logic [N-1:0] d;
        int           a;
        logic         l;
        sweep_exp = '{8'b10000000, 8'b01000000, 8'b00100000, 8'b00010000,
                      8'b00001000, 8'b00000100, 8'b00000010, 8'b00000001};

        // Reset state.
        @(negedge clk);
        #1;
        check("reset_down_valid", down_valid, 0);
        check("reset_up_ready", up_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_up_ready", up_ready, 1);

        // Single word with latency check.
        send(8'b10110101, 3, 1'b0, 8'b10110110);
        #1;
        check("latency_edge_t", down_valid, 0);
        @(negedge clk);
        #1;
        check("latency_edge_t1", down_valid, 0);
        @(negedge clk);
        #1;
        check("latency_edge_t2", down_valid, 1);
        drain();

        // Amount sweep, boundary amount N-1 equals left rotation by one.
        for (int i = 0; i < N; i++) send(8'b10000000, i, 1'b0, sweep_exp[i]);
        send(8'b10110101, N - 1, 1'b0, 8'b01101011);
        drain();

        // Back-to-back random stream with down_ready held high.
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            d = N'($urandom);
            a = int'($urandom_range(N - 1, 0));
`ifdef CIRC_ROTATOR_BIDIR_EN
            l = 1'($urandom);
`else
            l = 1'b0;
`endif
            send(d, a, l, model(d, a, l));
        end
        check("stream_no_stall", stalls, 0);
        drain();

        // Backpressure: fill the pipeline with down_ready low.
        dr_level = 1'b0;
        send(8'h11, 1, 1'b0, model(8'h11, 1, 1'b0));
        send(8'h22, 2, 1'b0, model(8'h22, 2, 1'b0));
        send(8'h33, 3, 1'b0, model(8'h33, 3, 1'b0));
        #1;
        check("full_up_ready_low", up_ready, 0);
        check("full_down_valid", down_valid, 1);
        check("full_down_data", int'(down_data), int'(model(8'h11, 1, 1'b0)));
        up_valid  = 1'b1;
        up_data   = 8'h44;
        up_amount = W'(4);
        up_left   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("stall_up_ready_low", up_ready, 0);
        check("stall_hold_data", int'(down_data), int'(model(8'h11, 1, 1'b0)));
        @(negedge clk);
        dr_level = 1'b1;
        #1;
        check("release_same_cycle", up_ready, 1);
        exp_q.push_back(model(8'h44, 4, 1'b0));
        @(negedge clk);
        up_valid = 1'b0;
        send(8'h55, 5, 1'b0, model(8'h55, 5, 1'b0));
        drain();

        // Random down_ready toggling with random idle gaps upstream.
        rand_mode = 1'b1;
        for (int i = 0; i < 30; i++) begin
            d = N'($urandom);
            a = int'($urandom_range(N - 1, 0));
`ifdef CIRC_ROTATOR_BIDIR_EN
            l = 1'($urandom);
`else
            l = 1'b0;
`endif
            send(d, a, l, model(d, a, l));
            repeat ($urandom_range(1, 0)) @(negedge clk);
        end
        rand_mode = 1'b0;
        dr_level  = 1'b1;
        drain();

        // Reset mid-flight discards in-flight words.
        send(8'hA5, 1, 1'b0, model(8'hA5, 1, 1'b0));
        send(8'h5A, 2, 1'b0, model(8'h5A, 2, 1'b0));
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_up_ready", up_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("midreset_down_valid", down_valid, 0);
            @(negedge clk);
        end
        send(8'b11100000, 2, 1'b0, 8'b00111000);
        drain();

`ifdef CIRC_ROTATOR_BIDIR_EN
        send(8'b10110101, 3, 1'b1, 8'b10101101);
        send(8'b10110101, 3, 1'b0, 8'b10110110);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
